inert_spi_serf: RTL
===================

Name: inert_spi_serf

Overview:
Synthesizable SPI responder that models the inertial sensor for the eBike bench and FPGA self-test. It is the serf end of the 16-bit SPI link driven by the inertial interface. It decodes read/write frames into a small register map, periodically snapshots roll/yaw rate and Y/Z acceleration from input ports into readable data registers, and raises INT when a fresh sample is ready.

Parameters:
ODR_DIV, 16'd2048, clk cycles between sample ticks (output-data-rate period)
WHO_AM_I_VAL, 8'h6A, constant returned on reads of address 0x0F

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  SPI select from monarch, active low
SCLK  in  1  SPI clock from monarch; idles high; period ≥ 8 clk cycles
MOSI  in  1  serial command/data, MSB first
MISO  out  1  serial response, MSB first
INT  out  1  data-ready interrupt, active high
roll_rt  in  16  signed roll rate sample source
yaw_rt  in  16  signed yaw rate sample source
AY  in  16  signed Y acceleration sample source
AZ  in  16  signed Z acceleration sample source

Behaviour:
- Clock/reset: clk; reset rst_n, asynchronous, active-low. All flops reset asynchronously.
- Reset values: MISO=0, INT=0, all config regs 0x00, data regs 0x0000, bit count 0, state IDLE.
- Synchronisation: SS_n, SCLK and MOSI each pass through 2 flops. A third SCLK flop gives edge detection: sclk_rise = ff2 & ~ff3 and sclk_fall = ~ff2 & ff3. SS_n uses the same scheme, giving ss_fall and ss_rise.
- Frame: 16 bits. cmd[15]=1 means read, 0 means write. cmd[14:8] is the 7-bit address. cmd[7:0] is write data, ignored on reads.
- State machine:
  - IDLE -> SHIFT on ss_fall: clear bit count and rx shift register; MISO=0.
  - SHIFT: on each sclk_rise, rx <= {rx[14:0], MOSI_sync} and bit count increments.
  - SHIFT, when bit count reaches 8: if rx[7]=1 (read), load tx_byte with the register at rx[6:0] in the next clk cycle.
  - SHIFT, bits 8-15: MISO = tx_byte[7], and tx_byte shifts left on each sclk_fall. MISO=0 during bits 0-7 and for write frames.
  - SHIFT -> IDLE on ss_rise. If bit count==16 and the frame is a write, the write commits in that cycle. If bit count≠16, the frame is discarded with no write and no INT clear.
- Register map:
  - 0x0D INT1_CTRL: R/W; bit1 enables data-ready INT.
  - 0x10, 0x11, 0x14: R/W config, storage only.
  - 0x0F: read-only WHO_AM_I_VAL.
  - 0x24/0x25: roll L/H. 0x26/0x27: yaw L/H. 0x2A/0x2B: AY L/H. 0x2C/0x2D: AZ L/H. All read-only.
  - Unmapped reads return 0x00. Writes to read-only or unmapped addresses are ignored.
- Sample tick: a free-running counter counts to ODR_DIV-1, then wraps and raises a tick.
  - On tick with SS_n_sync high: all four inputs are captured into the data regs together in one cycle.
  - On tick with a frame in progress: capture is deferred until the cycle after ss_rise. Multiple deferred ticks collapse into one.
- INT: set in the capture cycle when INT1_CTRL[1]=1. Cleared on completion (ss_rise, 16 bits) of a read of 0x2D.
  - If capture and clear fall in the same cycle, the set wins.
  - Writing INT1_CTRL[1]=0 clears INT immediately.
- Read latency: data is valid on MISO from the first sclk_fall after the 8th sclk_rise. The SPI monarch's SCLK low phase of ≥4 clk cycles leaves 2+ cycles of margin.
- Reset mid-frame: frame aborted, state IDLE; a subsequent ss_fall starts a clean frame.

Test Plan:
- Reset, then read frame 0x8F00 -> resp[7:0]=0x6A; MISO=0 for bits 0-7; INT stays 0.
- Write 0x0D02, then read 0x8D00 -> resp[7:0]=0x02. Write 0x1053, then read 0x9000 -> 0x53.
- INT1_CTRL=0x02, roll_rt=16'h1234, AZ=16'hFEDC; wait ODR_DIV cycles -> INT=1. Reads of 0xA4/0xA5 return 0x34/0x12; read of 0xAD returns 0xFE and INT=0 after ss_rise.
- Tick occurring mid-frame while reading 0xA4 -> the returned byte reflects the old snapshot; the new values are captured the cycle after ss_rise and INT then rises.
- SS_n raised after 10 bits of write 0x1150 -> register 0x11 unchanged (read back 0x00).
- Write 0x2455 (read-only) -> read 0xA400 still returns the sampled value, not 0x55.

Source files
------------

// File: rtl/inert_spi_serf_if.sv
// SPI link between the inertial-interface monarch and the sensor serf.
// The serf samples SS_n/SCLK/MOSI and drives MISO.
interface inert_spi_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_serf.sv
// Inertial-sensor SPI serf: 16-bit frames decoded into a small register map, periodic sample snapshots, data-ready INT.
// MISO is valid from the first SCLK fall after the 8th rise; there is no backpressure, and frames are paced only by the monarch.
module inert_spi_serf #(
  parameter logic [15:0] ODR_DIV      = 16'd2048,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic               clk,
  input  logic               rst_n,
  inert_spi_serf_if.slave    spi,
  output logic               INT,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  input  logic signed [15:0] AY,
  input  logic signed [15:0] AZ
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state, w_nxt_state;
  logic               r_ss_q1, r_ss_q2, r_ss_q3;
  logic               r_sclk_q1, r_sclk_q2, r_sclk_q3;
  logic               r_mosi_q1, r_mosi_q2;
  logic [4:0]         r_bit_cnt;
  logic [15:0]        r_rx;
  logic [7:0]         r_tx;
  logic               r_loaded, r_rd;
  logic [7:0]         r_int1_ctrl, r_cfg10, r_cfg11, r_cfg14;
  logic signed [15:0] r_roll, r_yaw, r_ay, r_az;
  logic [15:0]        r_odr_cnt;
  logic               r_defer, r_cap_late, r_int;
  logic               w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic               w_frame_done, w_wr_en, w_int_clr, w_tick, w_cap;
  logic [7:0]         w_rd_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_ss_q1, r_ss_q2, r_ss_q3}       <= 3'b111;
      {r_sclk_q1, r_sclk_q2, r_sclk_q3} <= 3'b111;
      {r_mosi_q1, r_mosi_q2}            <= 2'b00;
    end else begin
      {r_ss_q1, r_ss_q2, r_ss_q3}       <= {spi.SS_n, r_ss_q1, r_ss_q2};
      {r_sclk_q1, r_sclk_q2, r_sclk_q3} <= {spi.SCLK, r_sclk_q1, r_sclk_q2};
      {r_mosi_q1, r_mosi_q2}            <= {spi.MOSI, r_mosi_q1};
    end
  end

  assign w_ss_fall   = ~r_ss_q2 &  r_ss_q3;
  assign w_ss_rise   =  r_ss_q2 & ~r_ss_q3;
  assign w_sclk_rise =  r_sclk_q2 & ~r_sclk_q3;
  assign w_sclk_fall = ~r_sclk_q2 &  r_sclk_q3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_frame_done = 1'b0;
    w_wr_en      = 1'b0;
    w_int_clr    = 1'b0;
    case (r_state)
      IDLE:  if (w_ss_fall) w_nxt_state = SHIFT;
      SHIFT: begin
        if (w_ss_rise) w_nxt_state = IDLE;
        // Only a complete 16-bit frame may commit a write or clear INT.
        w_frame_done = w_ss_rise && (r_bit_cnt == 5'd16);
        w_wr_en      = w_frame_done && !r_rx[15];
        w_int_clr    = (w_frame_done && r_rx[15] && (r_rx[14:8] == 7'h2D)) ||
                       (w_wr_en && (r_rx[14:8] == 7'h0D) && !r_rx[1]);
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    w_rd_dat = 8'h00;
    case (r_rx[6:0])
      7'h0D: w_rd_dat = r_int1_ctrl;
      7'h0F: w_rd_dat = WHO_AM_I_VAL;
      7'h10: w_rd_dat = r_cfg10;
      7'h11: w_rd_dat = r_cfg11;
      7'h14: w_rd_dat = r_cfg14;
      7'h24: w_rd_dat = r_roll[7:0];
      7'h25: w_rd_dat = r_roll[15:8];
      7'h26: w_rd_dat = r_yaw[7:0];
      7'h27: w_rd_dat = r_yaw[15:8];
      7'h2A: w_rd_dat = r_ay[7:0];
      7'h2B: w_rd_dat = r_ay[15:8];
      7'h2C: w_rd_dat = r_az[7:0];
      7'h2D: w_rd_dat = r_az[15:8];
      default: w_rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 5'd0;
      r_rx      <= 16'h0000;
      r_tx      <= 8'h00;
      r_loaded  <= 1'b0;
      r_rd      <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_ss_fall) begin
        r_bit_cnt <= 5'd0;
        r_rx      <= 16'h0000;
        r_loaded  <= 1'b0;
        r_rd      <= 1'b0;
      end
    end else begin
      if (w_sclk_rise) begin
        r_rx      <= {r_rx[14:0], r_mosi_q2};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      // The first fall after the 8th rise presents tx[7] unshifted; later falls advance the byte.
      if (r_bit_cnt == 5'd8 && !r_loaded) begin
        r_loaded <= 1'b1;
        r_rd     <= r_rx[7];
        if (r_rx[7]) r_tx <= w_rd_dat;
      end else if (w_sclk_fall && r_bit_cnt >= 5'd9 && r_bit_cnt <= 5'd15) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign spi.MISO = (r_state == SHIFT) && r_loaded && r_rd && r_tx[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int1_ctrl <= 8'h00;
      r_cfg10     <= 8'h00;
      r_cfg11     <= 8'h00;
      r_cfg14     <= 8'h00;
    end else if (w_wr_en) begin
      case (r_rx[14:8])
        7'h0D: r_int1_ctrl <= r_rx[7:0];
        7'h10: r_cfg10     <= r_rx[7:0];
        7'h11: r_cfg11     <= r_rx[7:0];
        7'h14: r_cfg14     <= r_rx[7:0];
        default: ;
      endcase
    end
  end

  assign w_tick = (r_odr_cnt == (ODR_DIV - 16'd1));
  // Never snapshot under an active frame; a held-off tick lands the cycle after SS_n rises.
  assign w_cap  = (w_tick && r_ss_q2) || r_cap_late;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_odr_cnt  <= 16'd0;
      r_defer    <= 1'b0;
      r_cap_late <= 1'b0;
      r_roll     <= 16'sd0;
      r_yaw      <= 16'sd0;
      r_ay       <= 16'sd0;
      r_az       <= 16'sd0;
      r_int      <= 1'b0;
    end else begin
      r_odr_cnt  <= w_tick ? 16'd0 : r_odr_cnt + 16'd1;
      r_defer    <= !w_ss_rise && (r_defer || (w_tick && !r_ss_q2));
      r_cap_late <= r_defer && w_ss_rise;
      if (w_cap) begin
        r_roll <= roll_rt;
        r_yaw  <= yaw_rt;
        r_ay   <= AY;
        r_az   <= AZ;
      end
      if (w_cap && r_int1_ctrl[1]) r_int <= 1'b1;
      else if (w_int_clr)          r_int <= 1'b0;
    end
  end

  assign INT = r_int;

endmodule
